// File: rtl/mem_access_unit.sv
// Load/store unit bridging a request/response handshake to a combinational-read data memory.
// Supports 24-bit word and byte accesses; byte stores use read-modify-write to preserve neighbours.
module mem_access_unit #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_rdata,
  output logic        rsp_error,
  output logic [23:0] mem_addr,
  output logic [23:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [23:0] mem_rdata,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Highest legal start address: a word spans addr..addr+2.
  localparam logic [23:0] MAX_ADDR = 24'(MEM_BYTES - 3);

  state_t      state, nextState;
  logic        accept;
  logic        inRange;
  logic        latWrite;
  logic        latByte;
  logic [7:0]  latByteData;
  logic [23:0] memAddr;
  logic [23:0] memWdata;
  logic [23:0] rspRdata;
  logic        rspError;
  logic [7:0]  errCount;

  assign accept  = req_valid && (state == IDLE);
  assign inRange = (req_addr <= MAX_ADDR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!inRange)                    nextState = RESP;
          else if (req_write && !req_byte) nextState = WRITE;
          else                             nextState = READ;
        end
      end
      READ: begin
        mem_read  = 1'b1;
        nextState = latWrite ? WRITE : RESP;
      end
      WRITE: begin
        mem_write = 1'b1;
        nextState = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latWrite <= 1'b0;
      latByte  <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      rspRdata <= '0;
      rspError <= 1'b0;
      errCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            latWrite <= req_write;
            latByte  <= req_byte;
            rspRdata <= '0;
            rspError <= !inRange;
            if (!inRange) begin
              if (errCount != 8'hFF) errCount <= errCount + 8'd1;
            end else begin
              memAddr <= req_addr;
              if (req_write && !req_byte) memWdata <= req_wdata;
            end
          end
        end
        READ: begin
          // Byte store merges the new top byte with the two trailing bytes just read.
          if (latWrite)     memWdata <= {latByteData, mem_rdata[15:0]};
          else if (latByte) rspRdata <= {16'h0, mem_rdata[23:16]};
          else              rspRdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) latByteData <= req_wdata[7:0];
  end

  assign mem_addr  = memAddr;
  assign mem_wdata = memWdata;
  assign rsp_rdata = rspRdata;
  assign rsp_error = rspError;
  assign err_count = errCount;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: behavioural byte memory, strobe monitor and
// hand-computed expectations for word/byte loads and stores, range errors, backpressure and reset.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic [23:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [23:0] rsp_rdata;
  logic        rsp_error;
  logic [23:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [23:0] mem_rdata;
  logic [7:0]  err_count;

  mem_access_unit #(.MEM_BYTES(128)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:127];
  int cyc = 0;
  int wrCount = 0;
  int rdCount = 0;
  int bothCount = 0;
  int wrCyc = 0;
  logic [23:0] wrData = '0;

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 24'd125)
      mem_rdata = {mem[mem_addr[6:0]], mem[mem_addr[6:0] + 7'd1], mem[mem_addr[6:0] + 7'd2]};
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_write) begin
      wrCount <= wrCount + 1;
      wrCyc   <= cyc + 1;
      wrData  <= mem_wdata;
      if (mem_addr <= 24'd125) begin
        mem[mem_addr[6:0]]        <= mem_wdata[23:16];
        mem[mem_addr[6:0] + 7'd1] <= mem_wdata[15:8];
        mem[mem_addr[6:0] + 7'd2] <= mem_wdata[7:0];
      end
    end
    if (mem_read) rdCount <= rdCount + 1;
    if (mem_read && mem_write) bothCount <= bothCount + 1;
  end

  int nChecks = 0;
  int nFail = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int accCyc;

  // Present one request at a negedge; returns cycles from accept edge to the edge seeing rsp_valid.
  task automatic issue(input logic w, input logic b, input logic [23:0] a,
                       input logic [23:0] d, output int lat);
    @(negedge clock);
    req_write = w; req_byte = b; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clock);
    #1;
    accCyc = cyc;
    req_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) lat = 99;
  endtask

  task automatic consume();
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int w0, r0;
    logic [7:0] e0;
    logic [23:0] hold;

    // Reset state
    repeat (2) @(negedge clock);
    checkVal("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkVal("rst_outs", {rsp_valid, rsp_error, mem_write, mem_read}, 32'd0);
    checkVal("rst_data", {8'd0, rsp_rdata}, 32'd0);
    checkVal("rst_maddr", {8'd0, mem_addr}, 32'd0);
    checkVal("rst_mwdata", {8'd0, mem_wdata}, 32'd0);
    checkVal("rst_errcnt", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;

    // Word store then load
    w0 = wrCount;
    issue(1'b1, 1'b0, 24'h000004, 24'hA1B2C3, lat);
    checkVal("wst_lat", lat, 2);
    checkVal("wst_wrcount", wrCount - w0, 1);
    checkVal("wst_wrcyc", wrCyc - accCyc, 1);
    checkVal("wst_wdata", {8'd0, wrData}, 32'hA1B2C3);
    checkVal("wst_rsp", {8'd0, rsp_error, rsp_rdata}, 32'd0);
    consume();
    issue(1'b0, 1'b0, 24'h000004, 24'h0, lat);
    checkVal("wld_lat", lat, 2);
    checkVal("wld_rdata", {8'd0, rsp_rdata}, 32'hA1B2C3);
    checkVal("wld_err", {31'd0, rsp_error}, 32'd0);
    consume();

    // Byte store RMW over 11 22 33 at 10..12
    issue(1'b1, 1'b0, 24'd10, 24'h112233, lat);
    consume();
    w0 = wrCount; r0 = rdCount;
    issue(1'b1, 1'b1, 24'd10, 24'h0000FF, lat);
    checkVal("bst_lat", lat, 3);
    checkVal("bst_rdcount", rdCount - r0, 1);
    checkVal("bst_wrcount", wrCount - w0, 1);
    checkVal("bst_wrcyc", wrCyc - accCyc, 2);
    checkVal("bst_wdata", {8'd0, wrData}, 32'hFF2233);
    checkVal("bst_rdata", {8'd0, rsp_rdata}, 32'd0);
    checkVal("bst_mem", {8'd0, mem[10], mem[11], mem[12]}, 32'hFF2233);
    consume();
    issue(1'b0, 1'b1, 24'd10, 24'h0, lat);
    checkVal("bld_lat", lat, 2);
    checkVal("bld_rdata", {8'd0, rsp_rdata}, 32'h0000FF);
    consume();

    // Range boundary
    issue(1'b1, 1'b0, 24'd125, 24'h010203, lat);
    consume();
    issue(1'b0, 1'b0, 24'd125, 24'h0, lat);
    checkVal("b125_lat", lat, 2);
    checkVal("b125_rsp", {7'd0, rsp_error, rsp_rdata}, 32'h010203);
    consume();
    e0 = err_count; w0 = wrCount; r0 = rdCount;
    issue(1'b0, 1'b0, 24'd126, 24'h0, lat);
    checkVal("b126_lat", lat, 1);
    checkVal("b126_rsp", {7'd0, rsp_error, rsp_rdata}, 32'h1000000);
    consume();
    issue(1'b1, 1'b0, 24'hFFFFFF, 24'h123456, lat);
    checkVal("bmax_lat", lat, 1);
    checkVal("bmax_rsp", {7'd0, rsp_error, rsp_rdata}, 32'h1000000);
    consume();
    checkVal("berr_strobes", (wrCount - w0) + (rdCount - r0), 0);
    checkVal("berr_count", {24'd0, err_count - e0}, 32'd2);

    // Backpressure
    issue(1'b0, 1'b0, 24'h000004, 24'h0, lat);
    hold = rsp_rdata;
    checkVal("bp_first", {8'd0, hold}, 32'hA1B2C3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkVal("bp_hold", {6'd0, rsp_valid, req_ready, rsp_rdata}, {6'd0, 1'b1, 1'b0, 24'hA1B2C3});
    end
    consume();
    @(negedge clock);
    checkVal("bp_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    checkVal("bp_maddr_hold", {8'd0, mem_addr}, 32'h000004);

    // Reset during the READ phase of a byte store
    w0 = wrCount;
    @(negedge clock);
    req_write = 1'b1; req_byte = 1'b1; req_addr = 24'd20; req_wdata = 24'h0000AA;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(negedge clock);
    checkVal("rm_inread", {31'd0, mem_read}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkVal("rm_outs", {rsp_valid, rsp_error, mem_write, mem_read}, 32'd0);
    checkVal("rm_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clock);
    checkVal("rm_nowrite", wrCount - w0, 0);
    checkVal("rm_data", {err_count, rsp_rdata}, 32'd0);
    reset_n = 1'b1;
    issue(1'b0, 1'b0, 24'h000004, 24'h0, lat);
    checkVal("rm_after_lat", lat, 2);
    checkVal("rm_after_rdata", {8'd0, rsp_rdata}, 32'hA1B2C3);
    checkVal("rm_bothstrobe", bothCount, 0);
    consume();

    // Saturation
    for (int i = 0; i < 255; i++) begin
      issue(1'b0, 1'b0, 24'd200, 24'h0, lat);
      consume();
    end
    checkVal("sat_255", {24'd0, err_count}, 32'd255);
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 1'b0, 24'h800000, 24'h0, lat);
      consume();
    end
    checkVal("sat_260", {24'd0, err_count}, 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFail);
    $finish;
  end

endmodule
